ysyx_22051013_regfile_sb: RTL

- Integer register file plus per-register write scoreboard. This block is the receiving end of the write-back interface.
- Consumes the WBU's wb_rd_ena/wb_rd_addr/wb_data writes.
- Serves IDU's two source reads with same-cycle write-through bypass.
- Tracks in-flight destination registers between issue and write-back, and raises a stall for RAW hazards the pipeline cannot forward.

---
 rtl/ysyx_22051013_regfile_sb_pkg.sv | 13 +
 rtl/ysyx_22051013_regfile_sb_if.sv | 51 +++++
 rtl/ysyx_22051013_sb_cnt.sv | 38 +++
 rtl/ysyx_22051013_regfile_sb.sv | 108 ++++++++++
 4 files changed

// File: rtl/ysyx_22051013_regfile_sb_pkg.sv
// Shared widths and constants for the register file and write scoreboard.
// The other files import it with import ysyx_22051013_regfile_sb_pkg::*.
package ysyx_22051013_regfile_sb_pkg;

  localparam int ysyx_22051013_DATA    = 64;
  localparam int ysyx_22051013_REGADDR = 5;
  localparam logic [63:0] ysyx_22051013_ZERO64 = 64'h0;
  localparam logic ysyx_22051013_RSTABLE = 1'b1;

  localparam int ysyx_22051013_NREG  = 32;
  localparam int ysyx_22051013_CNT_W = 2;

endpackage

// File: rtl/ysyx_22051013_regfile_sb_if.sv
// Bundle carrying the write-back, source-read, issue and kill traffic into the regfile.
// The master side (IDU/WBU) drives requests; the slave side (regfile) returns data and status.
interface ysyx_22051013_regfile_sb_if
  import ysyx_22051013_regfile_sb_pkg::*;
#(
  parameter int XLEN = ysyx_22051013_DATA
);
  logic                               wb_rd_ena;
  logic [ysyx_22051013_REGADDR-1:0]   wb_rd_addr;
  logic [XLEN-1:0]                    wb_data;

  logic [ysyx_22051013_REGADDR-1:0]   rs1_addr;
  logic [ysyx_22051013_REGADDR-1:0]   rs2_addr;
  logic                               rs1_ena;
  logic                               rs2_ena;
  logic [XLEN-1:0]                    rs1_data;
  logic [XLEN-1:0]                    rs2_data;

  // Issue handshake: an instruction transfers on a cycle where id_issue_valid
  // and issue_ready are both high. issue_ready never depends on id_issue_valid;
  // valid without ready is simply ignored and may be retried on a later cycle.
  logic                               id_issue_valid;
  logic                               id_rd_ena;
  logic [ysyx_22051013_REGADDR-1:0]   id_rd_addr;

  logic                               kill0_valid;
  logic [ysyx_22051013_REGADDR-1:0]   kill0_rd_addr;
  logic                               kill1_valid;
  logic [ysyx_22051013_REGADDR-1:0]   kill1_rd_addr;

  logic                               rs_stall;
  logic                               issue_ready;
  logic                               sb_err;

  modport master (
    output wb_rd_ena, wb_rd_addr, wb_data,
    output rs1_addr, rs2_addr, rs1_ena, rs2_ena,
    output id_issue_valid, id_rd_ena, id_rd_addr,
    output kill0_valid, kill0_rd_addr, kill1_valid, kill1_rd_addr,
    input  rs1_data, rs2_data, rs_stall, issue_ready, sb_err
  );

  modport slave (
    input  wb_rd_ena, wb_rd_addr, wb_data,
    input  rs1_addr, rs2_addr, rs1_ena, rs2_ena,
    input  id_issue_valid, id_rd_ena, id_rd_addr,
    input  kill0_valid, kill0_rd_addr, kill1_valid, kill1_rd_addr,
    output rs1_data, rs2_data, rs_stall, issue_ready, sb_err
  );

endinterface

// File: rtl/ysyx_22051013_sb_cnt.sv
// One pending-writer counter: applies issue/retire/kill events as a single net delta.
// A net result below zero clamps to zero and is reported on underflow for that cycle.
module ysyx_22051013_sb_cnt
  import ysyx_22051013_regfile_sb_pkg::*;
#(
  parameter int CNT_W = ysyx_22051013_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             ret,
  input  logic             k0,
  input  logic             k1,
  output logic [CNT_W-1:0] cnt,
  output logic             underflow
);

  logic [CNT_W+1:0] up;
  logic [CNT_W+1:0] dn;
  logic [CNT_W+1:0] diff;
  logic [CNT_W-1:0] cnt_nxt;

  // Overflow is impossible because the top blocks issue into a full counter.
  assign up        = {2'b00, cnt} + (CNT_W+2)'(inc);
  assign dn        = (CNT_W+2)'(ret) + (CNT_W+2)'(k0) + (CNT_W+2)'(k1);
  assign underflow = (dn > up);
  assign diff      = up - dn;
  assign cnt_nxt   = underflow ? '0 : diff[CNT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/ysyx_22051013_regfile_sb.sv
// Integer register file with write-through bypass and a per-register pending-writer
// scoreboard that stalls RAW hazards the pipeline cannot forward.
module ysyx_22051013_regfile_sb
  import ysyx_22051013_regfile_sb_pkg::*;
#(
  parameter int XLEN  = ysyx_22051013_DATA,
  parameter int NREG  = ysyx_22051013_NREG,
  parameter int CNT_W = ysyx_22051013_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst,
  ysyx_22051013_regfile_sb_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [XLEN-1:0]             regs [1:NREG-1];
  logic [NREG-1:0][CNT_W-1:0]  cnt;
  logic [NREG-1:1]             uf;
  logic                        sb_err_q;

  logic wb_wr;
  logic byp1;
  logic byp2;
  logic hz1;
  logic hz2;
  logic rd_full;
  logic acc;

  assign wb_wr = bus.wb_rd_ena && (bus.wb_rd_addr != '0);
  assign byp1  = bus.wb_rd_ena && (bus.wb_rd_addr == bus.rs1_addr);
  assign byp2  = bus.wb_rd_ena && (bus.wb_rd_addr == bus.rs2_addr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      for (int i = 1; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_wr) begin
      regs[bus.wb_rd_addr] <= bus.wb_data;
    end
  end

  always_comb begin
    bus.rs1_data = ysyx_22051013_ZERO64[XLEN-1:0];
    bus.rs2_data = ysyx_22051013_ZERO64[XLEN-1:0];
    if (bus.rs1_addr != '0) begin
      bus.rs1_data = byp1 ? bus.wb_data : regs[bus.rs1_addr];
    end
    if (bus.rs2_addr != '0) begin
      bus.rs2_data = byp2 ? bus.wb_data : regs[bus.rs2_addr];
    end
  end

  // A single pending writer retiring this very cycle is covered by the bypass.
  function automatic logic hazard(input logic ena, input logic nz,
                                  input logic [CNT_W-1:0] c, input logic byp);
    hazard = ena && nz && ((c > CNT_W'(1)) || ((c == CNT_W'(1)) && !byp));
  endfunction

  assign hz1 = hazard(bus.rs1_ena, bus.rs1_addr != '0, cnt[bus.rs1_addr], byp1);
  assign hz2 = hazard(bus.rs2_ena, bus.rs2_addr != '0, cnt[bus.rs2_addr], byp2);

  assign rd_full         = bus.id_rd_ena && (bus.id_rd_addr != '0) &&
                           (cnt[bus.id_rd_addr] == CNT_MAX);
  assign bus.rs_stall    = hz1 | hz2;
  assign bus.issue_ready = !(hz1 | hz2) && !rd_full;
  assign acc             = bus.id_issue_valid && bus.issue_ready;

  assign cnt[0] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_cnt
    logic inc_r;
    logic ret_r;
    logic k0_r;
    logic k1_r;

    assign inc_r = acc && bus.id_rd_ena &&
                   (bus.id_rd_addr == ysyx_22051013_REGADDR'(r));
    assign ret_r = bus.wb_rd_ena && (bus.wb_rd_addr == ysyx_22051013_REGADDR'(r));
    assign k0_r  = bus.kill0_valid && (bus.kill0_rd_addr == ysyx_22051013_REGADDR'(r));
    assign k1_r  = bus.kill1_valid && (bus.kill1_rd_addr == ysyx_22051013_REGADDR'(r));

    ysyx_22051013_sb_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc_r),
      .ret       (ret_r),
      .k0        (k0_r),
      .k1        (k1_r),
      .cnt       (cnt[r]),
      .underflow (uf[r])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == ysyx_22051013_RSTABLE) begin
      sb_err_q <= 1'b0;
    end else if (|uf) begin
      sb_err_q <= 1'b1;
    end
  end

  assign bus.sb_err = sb_err_q;

endmodule
